seq_collector: RTL and testbench
================================

// Module: seq_collector
// PURPOSE
//  Receive end of the byte-sequence link driven by the Sequencer. Assembles the byte stream
//  (seq_byte/seq_valid, framed by seq_en/seq_done) back into a right-aligned 32-bit word.
//  Pulses word_valid once per good frame and flags malformed or aborted frames.
//  Sits between the link and the register/compare logic that consumes the reconstructed word.
// PARAMETERS
//  BYTE_W      8   width of one sequence element
//  WORD_BYTES  4   maximum bytes per frame; word_out width = BYTE_W*WORD_BYTES
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst_n      in   1   asynchronous active-low reset
//  seq_en     in   1   sender frame enable; a rising edge starts a frame
//  n          in   8   bytes per frame, sampled at frame start
//  seq_valid  in   1   seq_byte is valid this cycle
//  seq_byte   in   8   incoming byte, MSB-first
//  seq_done   in   1   sender end-of-frame pulse
//  word_out   out  32  assembled word, held until the next good frame
//  word_valid out  1   1-cycle pulse when word_out updates
//  busy       out  1   high in COLLECT/CHECK
//  frame_err  out  1   1-cycle pulse: short frame, abort or checksum mismatch
// BEHAVIOUR
//  Reset: state=IDLE; word_out=0, word_valid=0, busy=0, frame_err=0; shift reg and count cleared.
//  n_q = (n==0 || n>WORD_BYTES) ? WORD_BYTES : n. n is latched only at frame start.
//  IDLE: rising edge of seq_en (registered seq_en_d==0, seq_en==1) clears shreg and cnt, then -> COLLECT.
//    seq_valid and seq_done are ignored in IDLE. A frame starts only on an edge, so seq_en held high after DONE does not restart.
//  COLLECT: on seq_valid, shreg <= {shreg[23:0], seq_byte} and cnt <= cnt+1.
//    On the valid that makes cnt==n_q: -> CHECK if CHECKSUM_EN, else -> DONE.
//    seq_done with cnt+valid < n_q: frame_err pulse -> IDLE (short frame).
//    seq_done in the same cycle as the final byte is legal.
//    seq_en low: frame_err pulse -> IDLE (abort); word_out unchanged.
//  DONE (1 cycle): word_out <= shreg, right-aligned with upper bytes zero (n_q=3 -> 0x00XXXXXX).
//    word_valid=1 for that cycle, then -> IDLE.
//  Latency: word_valid asserts 1 cycle after the last byte's accepting edge.
//  Extra seq_valid after the count completes is ignored until the next frame.
//  The abort check has priority over byte capture in the same cycle.
//  Asserting rst_n mid-frame returns to IDLE at once. No partial word is published.
// CONFIGURATION
//  SEQ_COLLECT_CHECKSUM_EN defined:
//    - After the n_q data bytes the block waits in CHECK for one more valid byte.
//    - That byte must equal the XOR of the data bytes. Match -> DONE. Mismatch -> frame_err pulse, IDLE, word_out unchanged.
//    - seq_en low in CHECK aborts exactly as in COLLECT.
//  Undefined: CHECK state, XOR accumulator and compare are not built; COLLECT goes directly to DONE.
// STRUCTURE
//  Package seq_pkg: state enum (IDLE, COLLECT, CHECK, DONE).
//    Also holds the BYTE_W/WORD_BYTES defaults and the clamp function for n.
//  Single module, no sub-module. The FSM, counter and shift register are small enough to keep flat.
// TESTING
//  1 n=4, bytes AB,CD,EF,AB (seq_done on the last) -> word_out=0xABCDEFAB, one word_valid pulse, frame_err=0.
//  2 n=3, bytes AB,CD,EF -> word_out=0x00ABCDEF; n=0 and n=9 each behave as n=4.
//  3 n=4, seq_en drops after 2 bytes -> frame_err pulse, no word_valid, word_out keeps its previous value.
//  4 n=4, seq_done after 3 bytes -> frame_err pulse, return to IDLE.
//    A new seq_en edge then collects 11,22,33,44 -> 0x11223344.
//  5 rst_n low for 1 cycle mid-frame -> all outputs 0 immediately.
//    Next frame 01,02,03,04 -> 0x01020304.
//  6 CHECKSUM_EN, bytes 12,34,56,78 + 08 -> 0x12345678 valid. With 09 as the checksum -> frame_err, word_out unchanged.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the byte-sequence collector: default geometry,
// FSM state encoding and the frame-length clamp.
package seq_pkg;

    localparam int SEQ_BYTE_W     = 8;
    localparam int SEQ_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        DONE
    } state_e;

    // A zero or oversized byte count means "use the full word".
    function automatic logic [7:0] clamp_n(input logic [7:0] n, input logic [7:0] max_bytes);
        return (n == 8'd0 || n > max_bytes) ? max_bytes : n;
    endfunction

endpackage

// File: rtl/seq_collector.sv
// seq_collector: receive end of the byte-sequence link. Shifts MSB-first bytes
// into a right-aligned word, publishes it with a one-cycle word_valid pulse and
// flags short, aborted or (optionally) checksum-failed frames on frame_err.
// Optional feature: define SEQ_COLLECT_CHECKSUM_EN to require a trailing XOR
// checksum byte after the data bytes (adds the CHECK state).
module seq_collector
    import seq_pkg::*;
#(
    parameter int BYTE_W     = SEQ_BYTE_W,
    parameter int WORD_BYTES = SEQ_WORD_BYTES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         seq_en,
    input  logic [7:0]                   n,
    input  logic                         seq_valid,
    input  logic [BYTE_W-1:0]            seq_byte,
    input  logic                         seq_done,
    output logic [BYTE_W*WORD_BYTES-1:0] word_out,
    output logic                         word_valid,
    output logic                         busy,
    output logic                         frame_err
);

    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int CNT_W  = $clog2(WORD_BYTES + 1);

    state_e              state_q, state_d;
    logic                seq_en_q;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                word_valid_q, word_valid_d;
    logic                frame_err_q, frame_err_d;
`ifdef SEQ_COLLECT_CHECKSUM_EN
    logic [BYTE_W-1:0]   xor_q, xor_d;
`endif

    logic                start;
    logic                last_byte;

    assign start      = seq_en & ~seq_en_q;
    assign last_byte  = seq_valid && ((cnt_q + CNT_W'(1)) == n_q);

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == COLLECT) || (state_q == CHECK);

    // State, datapath and output registers; reset returns to IDLE at once.
    // NOTE: every register here is a small flop, so all of them take the async reset; sequential state uses <= so each flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            seq_en_q     <= 1'b0;
            n_q          <= '0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SEQ_COLLECT_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            seq_en_q     <= seq_en;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef SEQ_COLLECT_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    // Next-state and datapath decode; aborts outrank byte capture.
    // NOTE: every _d gets a hold/default value first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef SEQ_COLLECT_CHECKSUM_EN
        xor_d        = xor_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = CNT_W'(clamp_n(n, 8'(WORD_BYTES)));
                    cnt_d   = '0;
                    shreg_d = '0;
`ifdef SEQ_COLLECT_CHECKSUM_EN
                    xor_d   = '0;
`endif
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (!seq_en) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    if (seq_valid) begin
                        shreg_d = {shreg_q[WORD_W-BYTE_W-1:0], seq_byte};
                        cnt_d   = cnt_q + CNT_W'(1);
`ifdef SEQ_COLLECT_CHECKSUM_EN
                        xor_d   = xor_q ^ seq_byte;
`endif
                    end
                    if (last_byte) begin
`ifdef SEQ_COLLECT_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else if (seq_done) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

`ifdef SEQ_COLLECT_CHECKSUM_EN
            CHECK: begin
                if (!seq_en) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (seq_valid) begin
                    if (seq_byte == xor_q) begin
                        state_d = DONE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
`endif

            DONE: begin
                word_d       = shreg_q;
                word_valid_d = 1'b1;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_collector.sv
// Self-checking bench for seq_collector: a table of frames is driven in a loop,
// each frame pushes its expected outcome to a scoreboard queue, and a monitor
// pops and compares whenever word_valid or frame_err pulses. Reset-mid-frame is
// a hand-written sequence. Define SEQ_COLLECT_CHECKSUM_EN for the checksum build.
module tb_seq_collector;

    typedef enum logic [2:0] {
        K_GOOD,          // n_q bytes, seq_done on the last one
        K_EXTRA,         // good frame followed by a stray valid byte
        K_ABORT,         // seq_en drops after len bytes
        K_ABORT_ON_BYTE, // seq_en drops in the same cycle as the last byte
        K_SHORT,         // seq_done arrives with fewer than n_q bytes
        K_BADSUM         // good data, wrong checksum byte
    } kind_e;

    typedef struct packed {
        logic [7:0]       n;
        logic [2:0]       len;
        logic [3:0][7:0]  bytes;
        kind_e            kind;
        logic [31:0]      exp_word;
    } frame_vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] word;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        seq_en;
    logic [7:0]  n;
    logic        seq_valid;
    logic [7:0]  seq_byte;
    logic        seq_done;
    logic [31:0] word_out;
    logic        word_valid;
    logic        busy;
    logic        frame_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb_q[$];
    frame_vec_t  vecs[$];
    logic [31:0] last_good;

    seq_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seq_en     (seq_en),
        .n          (n),
        .seq_valid  (seq_valid),
        .seq_byte   (seq_byte),
        .seq_done   (seq_done),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic frame_vec_t mk(input logic [7:0] nn, input logic [2:0] len,
                                      input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input logic [7:0] b3,
                                      input kind_e kind, input logic [31:0] exp_word);
        frame_vec_t v;
        v.n        = nn;
        v.len      = len;
        v.bytes[0] = b0;
        v.bytes[1] = b1;
        v.bytes[2] = b2;
        v.bytes[3] = b3;
        v.kind     = kind;
        v.exp_word = exp_word;
        return v;
    endfunction

    // Scoreboard consumer: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (word_valid !== 1'b0 || frame_err !== 1'b0)) begin
            if (sb_q.size() == 0) begin
                check("spurious_output", {30'd0, word_valid, frame_err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("frame_outcome", {30'd0, word_valid, frame_err}, {30'd0, ~e.err, e.err});
                check("word_out", word_out, e.word);
            end
        end
    end

    // Drive one frame from the table and queue its expected outcome.
    task automatic drive_frame(input frame_vec_t v);
        exp_t        e;
        logic [7:0]  csum;
        logic        is_err;
        is_err = (v.kind == K_ABORT) || (v.kind == K_ABORT_ON_BYTE) || (v.kind == K_SHORT);
`ifdef SEQ_COLLECT_CHECKSUM_EN
        is_err = is_err || (v.kind == K_BADSUM);
`endif
        csum = 8'h00;
        @(negedge clk);
        seq_en = 1'b1;
        n      = v.n;
        e.err  = is_err;
        e.word = is_err ? last_good : v.exp_word;
        if (!is_err) last_good = v.exp_word;
        sb_q.push_back(e);
        @(negedge clk);
        n = 8'hFF;  // must be ignored: n is only sampled at frame start
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int i = 0; i < int'(v.len); i++) begin
            seq_valid = 1'b1;
            seq_byte  = v.bytes[i];
            csum      = csum ^ v.bytes[i];
            seq_done  = (i == int'(v.len) - 1) &&
                        (v.kind != K_ABORT) && (v.kind != K_ABORT_ON_BYTE);
            if (v.kind == K_ABORT_ON_BYTE && i == int'(v.len) - 1) seq_en = 1'b0;
            @(negedge clk);
        end
        seq_done = 1'b0;
`ifdef SEQ_COLLECT_CHECKSUM_EN
        if (v.kind == K_GOOD || v.kind == K_EXTRA || v.kind == K_BADSUM) begin
            seq_valid = 1'b1;
            seq_byte  = (v.kind == K_BADSUM) ? (csum ^ 8'h01) : csum;
            @(negedge clk);
        end
`endif
        if (v.kind == K_EXTRA) begin
            seq_valid = 1'b1;
            seq_byte  = 8'h99;
            @(negedge clk);
        end
        seq_valid = 1'b0;
        if (v.kind == K_ABORT) seq_en = 1'b0;
        repeat (3) @(negedge clk);   // seq_en held high after DONE must not restart
        seq_en = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        seq_en    = 1'b0;
        n         = 8'd0;
        seq_valid = 1'b0;
        seq_byte  = 8'h00;
        seq_done  = 1'b0;
        last_good = 32'h0;

        repeat (2) @(negedge clk);
        check("reset_word_out",   word_out, 32'h0);
        check("reset_word_valid", {31'd0, word_valid}, 32'd0);
        check("reset_busy",       {31'd0, busy}, 32'd0);
        check("reset_frame_err",  {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Seq_valid/seq_done while idle must be ignored.
        seq_valid = 1'b1; seq_byte = 8'h55; seq_done = 1'b1;
        repeat (2) @(negedge clk);
        seq_valid = 1'b0; seq_done = 1'b0;
        check("idle_ignores_bytes", {31'd0, busy}, 32'd0);

        vecs.push_back(mk(8'd4, 3'd4, 8'hAB, 8'hCD, 8'hEF, 8'hAB, K_GOOD,  32'hABCDEFAB));
        vecs.push_back(mk(8'd3, 3'd3, 8'hAB, 8'hCD, 8'hEF, 8'h00, K_GOOD,  32'h00ABCDEF));
        vecs.push_back(mk(8'd0, 3'd4, 8'h01, 8'h23, 8'h45, 8'h67, K_GOOD,  32'h01234567));
        vecs.push_back(mk(8'd9, 3'd4, 8'h89, 8'hAB, 8'hCD, 8'hEF, K_GOOD,  32'h89ABCDEF));
        vecs.push_back(mk(8'd4, 3'd2, 8'hDE, 8'hAD, 8'h00, 8'h00, K_ABORT, 32'h0));
        vecs.push_back(mk(8'd4, 3'd3, 8'h11, 8'h22, 8'h33, 8'h00, K_SHORT, 32'h0));
        vecs.push_back(mk(8'd4, 3'd4, 8'h11, 8'h22, 8'h33, 8'h44, K_GOOD,  32'h11223344));
        vecs.push_back(mk(8'd1, 3'd1, 8'h5A, 8'h00, 8'h00, 8'h00, K_GOOD,  32'h0000005A));
        vecs.push_back(mk(8'd2, 3'd2, 8'hC3, 8'h3C, 8'h00, 8'h00, K_EXTRA, 32'h0000C33C));
        vecs.push_back(mk(8'd2, 3'd2, 8'h77, 8'h88, 8'h00, 8'h00, K_ABORT_ON_BYTE, 32'h0));
`ifdef SEQ_COLLECT_CHECKSUM_EN
        vecs.push_back(mk(8'd4, 3'd4, 8'h12, 8'h34, 8'h56, 8'h78, K_GOOD,   32'h12345678));
        vecs.push_back(mk(8'd4, 3'd4, 8'h12, 8'h34, 8'h56, 8'h78, K_BADSUM, 32'h0));
`endif

        foreach (vecs[i]) drive_frame(vecs[i]);

        // Reset mid-frame: everything clears at once, no partial word appears.
        @(negedge clk);
        seq_en = 1'b1; n = 8'd4;
        @(negedge clk);
        seq_valid = 1'b1; seq_byte = 8'hEE;
        @(negedge clk);
        seq_byte = 8'hFF;
        @(negedge clk);
        seq_valid = 1'b0;
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2;
        rst_n  = 1'b0;
        seq_en = 1'b0;
        #1;
        check("midreset_word_out",   word_out, 32'h0);
        check("midreset_busy",       {31'd0, busy}, 32'd0);
        check("midreset_word_valid", {31'd0, word_valid}, 32'd0);
        check("midreset_frame_err",  {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        last_good = 32'h0;
        @(negedge clk);
        drive_frame(mk(8'd4, 3'd4, 8'h01, 8'h02, 8'h03, 8'h04, K_GOOD, 32'h01020304));

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        check("final_word_out", word_out, 32'h01020304);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
